// File: rtl/alu_control_unit_pkg.sv
// Shared types and constants for the ALU control unit: FSM encoding, instruction
// field layout, ALU opcodes and datapath widths.
package alu_control_unit_pkg;

  localparam int DATA_W    = 4;
  localparam int REG_IDX_W = 2;
  localparam int OPC_W     = 3;
  localparam int INSTR_W   = 14;

  // Instruction field bit positions (LSB of each field)
  localparam int OPC_LSB     = 11;
  localparam int RD_LSB      = 9;
  localparam int RA_LSB      = 7;
  localparam int RB_LSB      = 5;
  localparam int IMM_SEL_BIT = 4;
  localparam int IMM_LSB     = 0;

  localparam logic [OPC_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [OPC_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [OPC_W-1:0] ALU_AND   = 3'b010;
  localparam logic [OPC_W-1:0] ALU_SHIFT = 3'b011;
  localparam logic [OPC_W-1:0] ALU_OR    = 3'b100;
  localparam logic [OPC_W-1:0] ALU_XOR   = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [OPC_W-1:0]     opcode;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] ra;
    logic [REG_IDX_W-1:0] rb;
    logic                 imm_sel;
    logic [DATA_W-1:0]    imm;
  } instr_t;

  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
    instr_t d;
    d.opcode  = raw[OPC_LSB +: OPC_W];
    d.rd      = raw[RD_LSB +: REG_IDX_W];
    d.ra      = raw[RA_LSB +: REG_IDX_W];
    d.rb      = raw[RB_LSB +: REG_IDX_W];
    d.imm_sel = raw[IMM_SEL_BIT];
    d.imm     = raw[IMM_LSB +: DATA_W];
    return d;
  endfunction

endpackage

// File: rtl/regfile_4x4.sv
// Four 4-bit registers: two combinational read ports, one synchronous write port,
// synchronous active-high reset clearing every entry.
module regfile_4x4
  import alu_control_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] ra_idx,
  input  logic [REG_IDX_W-1:0] rb_idx,
  output logic [DATA_W-1:0]    ra_data,
  output logic [DATA_W-1:0]    rb_data,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_idx,
  input  logic [DATA_W-1:0]    wr_data
);

  logic [DATA_W-1:0] mem_q [4];
  logic [DATA_W-1:0] mem_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) mem_d[i] = mem_q[i];
    if (wr_en) mem_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign ra_data = mem_q[ra_idx];
  assign rb_data = mem_q[rb_idx];

endmodule

// File: rtl/alu_control_unit.sv
// Sequences one instruction at a time through an external ALU: IDLE accepts,
// ISSUE drives the ALU for one cycle and writes back, RESP holds the result.
module alu_control_unit
  import alu_control_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [INSTR_W-1:0]   instr,
  output logic [OPC_W-1:0]     alu_opcode,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_W-1:0]    res_data,
  output logic                 res_zero,
  output logic                 res_overflow,
  output logic [REG_IDX_W-1:0] res_rd,
  output logic [7:0]           instr_count
);

  // Both handshakes are plain valid/ready: a transfer happens on a rising edge
  // where valid and ready are both high; the producer holds its payload until then.

  state_e               state_q, state_d;
  instr_t               dec;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic [OPC_W-1:0]     alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic                 res_valid_q, res_valid_d;
  logic [DATA_W-1:0]    res_data_q, res_data_d;
  logic                 res_zero_q, res_zero_d, res_overflow_q, res_overflow_d;
  logic [REG_IDX_W-1:0] res_rd_q, res_rd_d;
  logic [7:0]           count_q, count_d;
  logic [DATA_W-1:0]    ra_data, rb_data;
  logic                 wr_en;

  assign dec = decode_instr(instr);

  // Operands are read from the incoming instruction while in IDLE; any earlier
  // writeback has already landed, since the previous ISSUE has completed.
  regfile_4x4 u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_idx  (dec.ra),
    .rb_idx  (dec.rb),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .wr_en   (wr_en),
    .wr_idx  (rd_q),
    .wr_data (alu_result)
  );

  always_comb begin
    state_d        = state_q;
    rd_d           = rd_q;
    alu_opcode_d   = alu_opcode_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    res_valid_d    = res_valid_q;
    res_data_d     = res_data_q;
    res_zero_d     = res_zero_q;
    res_overflow_d = res_overflow_q;
    res_rd_d       = res_rd_q;
    count_d        = count_q;
    wr_en          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          state_d      = ST_ISSUE;
          rd_d         = dec.rd;
          alu_opcode_d = dec.opcode;
          alu_a_d      = ra_data;
          alu_b_d      = dec.imm_sel ? dec.imm : rb_data;
        end
      end
      ST_ISSUE: begin
        wr_en          = 1'b1;
        res_valid_d    = 1'b1;
        res_data_d     = alu_result;
        res_zero_d     = alu_zero;
        res_overflow_d = alu_overflow;
        res_rd_d       = rd_q;
        state_d        = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          count_d     = count_q + 8'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      rd_q           <= '0;
      alu_opcode_q   <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_zero_q     <= 1'b0;
      res_overflow_q <= 1'b0;
      res_rd_q       <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      rd_q           <= rd_d;
      alu_opcode_q   <= alu_opcode_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      res_zero_q     <= res_zero_d;
      res_overflow_q <= res_overflow_d;
      res_rd_q       <= res_rd_d;
      count_q        <= count_d;
    end
  end

  assign instr_ready  = (state_q == ST_IDLE);
  assign alu_opcode   = alu_opcode_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_zero     = res_zero_q;
  assign res_overflow = res_overflow_q;
  assign res_rd       = res_rd_q;
  assign instr_count  = count_q;

endmodule
